// File: rtl/fifo_fwft_adapter_pkg.sv
// Shared definitions for the fifo_synch first-word-fall-through read stage.
//   DATA_WIDTH_DEF : default word width, equal to MEMORY_WIDTH of fifo_synch
//   occ_e          : buffer occupancy encodings (EMPTY / ONE / TWO)
//   pending_words  : words buffered plus in flight, minus the word leaving
package fifo_fwft_adapter_pkg;

  localparam int DATA_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Evaluated at 3 bits so the subtraction of a popped word cannot wrap.
  function automatic logic [2:0] pending_words(input logic [1:0] occ,
                                               input logic       inflight,
                                               input logic       pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_fwft_adapter_if.sv
// Handshake bundle between fifo_synch, the FWFT adapter and the downstream sink.
//   fifo_empty / fifo_rdata / fifo_r_en : pop interface of fifo_synch
//   out_valid / out_ready / out_data    : first-word-fall-through stream
//   occupancy                           : words held in the adapter (0..2)
// Modports: master = adapter side, slave = FIFO/sink side, monitor = observer.
interface fifo_fwft_adapter_if
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_r_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            occupancy;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_r_en, out_valid, out_data, occupancy
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_r_en, out_valid, out_data, occupancy
  );

  modport monitor (
    input fifo_empty, fifo_rdata, fifo_r_en, out_valid, out_ready, out_data, occupancy
  );

endinterface

// File: rtl/fifo_fwft_adapter_chk.sv
// Invariant checker for the FWFT adapter, attached to the interface from outside.
// Ports:
//   clk, rst_n : same clock/reset as the adapter
//   bus        : fifo_fwft_adapter_if.monitor
// The in-flight flag is rebuilt here by registering fifo_r_en.
module fifo_fwft_adapter_chk (
  input logic                  clk,
  input logic                  rst_n,
  fifo_fwft_adapter_if.monitor bus
);

  logic inflight_r;

  // Mirror of the adapter's in-flight flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= bus.fifo_r_en;
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
    bus.occupancy <= 2'd2);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, bus.occupancy} + {2'b00, inflight_r}) <= 3'd2);

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.fifo_r_en && bus.fifo_empty));

  a_no_push_pop_in_two: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_r && bus.out_valid && bus.out_ready && (bus.occupancy == 2'd2)));

  a_valid_matches_occ: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid == (bus.occupancy != 2'd0));

endmodule

// File: rtl/fifo_fwft_adapter.sv
// FWFT read stage for fifo_synch: prefetches into a 2-entry head/skid buffer so the
// sink sees the head word with no read latency, sustaining 1 word/clk.
// Ports:
//   clk   : single clock, all state on posedge
//   rst_n : synchronous active-low reset; also forces fifo_r_en low
//   bus   : fifo_fwft_adapter_if.master (fifo_empty/fifo_rdata in, fifo_r_en out,
//           out_valid/out_data/occupancy out, out_ready in)
module fifo_fwft_adapter
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_fwft_adapter_if.master    bus
);

  occ_e                  occ_r;
  occ_e                  occ_nxt_s;
  logic                  inflight_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic [DATA_WIDTH-1:0] head_nxt_s;
  logic [DATA_WIDTH-1:0] skid_nxt_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  r_en_s;

  // State register: occupancy, in-flight flag, registered valid and the two slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r       <= OCC_EMPTY;
      inflight_r  <= 1'b0;
      out_valid_r <= 1'b0;
      head_r      <= {DATA_WIDTH{1'b0}};
      skid_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      occ_r       <= occ_nxt_s;
      inflight_r  <= r_en_s;
      out_valid_r <= (occ_nxt_s != OCC_EMPTY);
      head_r      <= head_nxt_s;
      skid_r      <= skid_nxt_s;
    end
  end

  // Next-state logic: a push is the read data landing one cycle after the r_en.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    skid_nxt_s = skid_r;
    case ({push_s, pop_s})
      2'b10: begin
        case (occ_r)
          OCC_EMPTY: begin
            head_nxt_s = bus.fifo_rdata;
            occ_nxt_s  = OCC_ONE;
          end
          OCC_ONE: begin
            skid_nxt_s = bus.fifo_rdata;
            occ_nxt_s  = OCC_TWO;
          end
          default: occ_nxt_s = occ_r;
        endcase
      end
      2'b01: begin
        case (occ_r)
          OCC_ONE: occ_nxt_s = OCC_EMPTY;
          OCC_TWO: begin
            head_nxt_s = skid_r;
            occ_nxt_s  = OCC_ONE;
          end
          default: occ_nxt_s = occ_r;
        endcase
      end
      2'b11: begin
        // Only reachable in ONE: the incoming word replaces the departing head.
        case (occ_r)
          OCC_ONE: head_nxt_s = bus.fifo_rdata;
          default: occ_nxt_s  = occ_r;
        endcase
      end
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Output logic: the read request looks through this cycle's pop (out_ready path).
  always_comb begin
    pop_s  = out_valid_r & bus.out_ready;
    push_s = inflight_r;
    if (rst_n && !bus.fifo_empty && (pending_words(occ_r, inflight_r, pop_s) < 3'd2)) begin
      r_en_s = 1'b1;
    end else begin
      r_en_s = 1'b0;
    end
  end

  assign bus.fifo_r_en = r_en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = head_r;
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Directed bench for fifo_fwft_adapter fed by a depth-4, width-4 fifo_synch model.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_fifo_fwft_adapter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_rst_n;
  logic       w_en;
  logic [3:0] wdata;
  int         errors = 0;
  int         checks = 0;

  // fifo_synch model
  logic [3:0] mem [4];
  logic [1:0] wptr, rptr;
  logic [2:0] cnt;
  logic [3:0] rdata_r;
  logic       do_wr, do_rd;

  fifo_fwft_adapter_if #(.DATA_WIDTH(4)) bus ();

  fifo_fwft_adapter #(.DATA_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fifo_fwft_adapter_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign do_wr          = w_en && (cnt != 3'd4);
  assign do_rd          = bus.fifo_r_en && (cnt != 3'd0);
  assign bus.fifo_empty = (cnt == 3'd0);
  assign bus.fifo_rdata = rdata_r;

  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      wptr    <= 2'd0;
      rptr    <= 2'd0;
      cnt     <= 3'd0;
      rdata_r <= 4'd0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 2'd1;
      end
      if (do_rd) begin
        rdata_r <= mem[rptr];
        rptr    <= rptr + 2'd1;
      end
      cnt <= cnt + {2'b00, do_wr} - {2'b00, do_rd};
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_rst_n = 1'b0; w_en = 1'b0; wdata = 4'd0; bus.out_ready = 1'b0;
    step(); step();
    fifo_rst_n = 1'b1; w_en = 1'b1; wdata = 4'd9;
    step();
    w_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b want 0", bus.fifo_r_en); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
      checks++; if (bus.out_data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
    end
    fifo_rst_n = 1'b0;
    step();
    fifo_rst_n = 1'b1; rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1; w_en = 1'b1; wdata = 4'd1;
    step(); wdata = 4'd2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: valid got %b want 0", bus.out_valid); end
    checks++; if (bus.fifo_r_en !== 1'b1) begin errors++; $display("FAIL stream_ren: got %b want 1", bus.fifo_r_en); end
    step(); wdata = 4'd3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat2: valid got %b want 0", bus.out_valid); end
    step(); w_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(k)) begin
        errors++; $display("FAIL stream_word%0d: got valid=%b data=%0d want valid=1 data=%0d", k, bus.out_valid, bus.out_data, k);
      end
      step();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL stream_end: got valid=%b occ=%0d want 0/0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0; w_en = 1'b1; wdata = 4'd1;
    step(); wdata = 4'd2;
    step(); wdata = 4'd3;
    step(); wdata = 4'd4;
    step(); w_en = 1'b0;
    step(); step();
    checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", bus.occupancy); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd1) begin errors++; $display("FAIL bp_head: got valid=%b data=%0d want 1/1", bus.out_valid, bus.out_data); end
    checks++; if (bus.fifo_r_en !== 1'b0) begin errors++; $display("FAIL bp_ren: got %b want 0", bus.fifo_r_en); end
    checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL bp_fifo_words: got %0d want 2", cnt); end
  endtask

  task automatic test_empty_guard();
    logic guard_ok;
    guard_ok = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.fifo_r_en && bus.fifo_empty) guard_ok = 1'b0;
      checks++;
      if (c < 4) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(c + 1)) begin
          errors++; $display("FAIL drain_word%0d: got valid=%b data=%0d want valid=1 data=%0d", c + 1, bus.out_valid, bus.out_data, c + 1);
        end
      end else begin
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle%0d: valid got %b want 0", c, bus.out_valid); end
      end
      step();
    end
    checks++; if (guard_ok !== 1'b1) begin errors++; $display("FAIL empty_guard: r_en seen while empty"); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL drain_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_toggled_ready();
    logic [3:0] rx [8];
    int         n;
    logic       prev_stall;
    logic [3:0] prev_data;
    n = 0; prev_stall = 1'b0; prev_data = 4'd0;
    for (int i = 0; i < 30; i++) begin
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          errors++; $display("FAIL toggle_stable: got valid=%b data=%0d want valid=1 data=%0d", bus.out_valid, bus.out_data, prev_data);
        end
      end
      w_en = (i < 4);
      wdata = 4'(5 + i);
      bus.out_ready = (i % 2 == 0);
      if (bus.out_valid && bus.out_ready) begin
        if (n < 8) rx[n] = bus.out_data;
        n++;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      step();
    end
    w_en = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL toggle_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < n && rx[k] !== 4'(5 + k)) begin errors++; $display("FAIL toggle_word%0d: got %0d want %0d", k, rx[k], 5 + k); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] rx [8];
    int         n;
    n = 0;
    bus.out_ready = 1'b0; w_en = 1'b1; wdata = 4'd10;
    step(); wdata = 4'd11;
    step(); wdata = 4'd12;
    step();
    // head holds 10, word 11 is in flight
    checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL mid_pre_occ: got %0d want 1", bus.occupancy); end
    wdata = 4'd13; rst_n = 1'b0;
    #1;
    checks++; if (bus.fifo_r_en !== 1'b0) begin errors++; $display("FAIL mid_ren_in_reset: got %b want 0", bus.fifo_r_en); end
    step();
    w_en = 1'b0; rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL mid_occ: got %0d want 0", bus.occupancy); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid && bus.out_ready) begin
        if (n < 8) rx[n] = bus.out_data;
        n++;
      end
      step();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL mid_count: got %0d want 2", n); end
    checks++; if (n >= 1 && rx[0] !== 4'd12) begin errors++; $display("FAIL mid_word0: got %0d want 12", rx[0]); end
    checks++; if (n >= 2 && rx[1] !== 4'd13) begin errors++; $display("FAIL mid_word1: got %0d want 13", rx[1]); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_guard();
    test_toggled_ready();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
